// File: rtl/lcd_pkg.sv
// Shared constants for the parallel-RGB LCD driver: default 800x480 timing,
// 24-bit {R,G,B} colour values and helpers used by the timing and output stages.
package lcd_pkg;

  localparam int H_SYNC_DEF  = 1;
  localparam int H_BACK_DEF  = 46;
  localparam int H_DISP_DEF  = 800;
  localparam int H_FRONT_DEF = 210;
  localparam int V_SYNC_DEF  = 1;
  localparam int V_BACK_DEF  = 23;
  localparam int V_DISP_DEF  = 480;
  localparam int V_FRONT_DEF = 22;

  localparam logic [23:0] BLACK   = 24'h000000;
  localparam logic [23:0] WHITE   = 24'hFFFFFF;
  localparam logic [23:0] RED     = 24'hFF0000;
  localparam logic [23:0] GREEN   = 24'h00FF00;
  localparam logic [23:0] BLUE    = 24'h0000FF;
  localparam logic [23:0] YELLOW  = 24'hFFFF00;
  localparam logic [23:0] CYAN    = 24'h00FFFF;
  localparam logic [23:0] MAGENTA = 24'hFF00FF;

  // Line or frame length in clocks/lines; must stay <= 4096 for the 12-bit counters.
  function automatic int calc_total(int sync, int back, int disp, int front);
    return sync + back + disp + front;
  endfunction

  function automatic logic [23:0] bar_colour(logic [2:0] bar);
    logic [23:0] colour;
    case (bar)
      3'd0:    colour = WHITE;
      3'd1:    colour = YELLOW;
      3'd2:    colour = CYAN;
      3'd3:    colour = GREEN;
      3'd4:    colour = MAGENTA;
      3'd5:    colour = RED;
      3'd6:    colour = BLUE;
      default: colour = BLACK;
    endcase
    return colour;
  endfunction

endpackage

// File: rtl/lcd_driver_if.sv
// Pixel-request and panel-side signals of the LCD driver; the driver is the
// master, the pixel-data stage and panel pins sit on the slave side.
interface lcd_driver_if;

  logic [11:0] lcd_xpos;
  logic [11:0] lcd_ypos;
  logic        lcd_request;
  logic [23:0] lcd_data;
  logic        lcd_de;
  logic        lcd_hs;
  logic        lcd_vs;
  logic [23:0] lcd_rgb;
  logic        frame_start;

  modport master (
    output lcd_xpos, lcd_ypos, lcd_request,
    output lcd_de, lcd_hs, lcd_vs, lcd_rgb, frame_start,
    input  lcd_data
  );

  modport slave (
    input  lcd_xpos, lcd_ypos, lcd_request,
    input  lcd_de, lcd_hs, lcd_vs, lcd_rgb, frame_start,
    output lcd_data
  );

endinterface

// File: rtl/lcd_timing_counter.sv
// Free-running horizontal/vertical counters with the active-area and sync
// compares derived from them (stage 0 of the LCD timing pipeline).
module lcd_timing_counter
  import lcd_pkg::*;
#(
  parameter int H_SYNC  = H_SYNC_DEF,
  parameter int H_BACK  = H_BACK_DEF,
  parameter int H_DISP  = H_DISP_DEF,
  parameter int H_FRONT = H_FRONT_DEF,
  parameter int V_SYNC  = V_SYNC_DEF,
  parameter int V_BACK  = V_BACK_DEF,
  parameter int V_DISP  = V_DISP_DEF,
  parameter int V_FRONT = V_FRONT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  output logic [11:0] h_cnt,
  output logic [11:0] v_cnt,
  output logic        h_act,
  output logic        v_act,
  output logic        hs0,
  output logic        vs0
);

  localparam logic [11:0] H_LAST  = 12'(calc_total(H_SYNC, H_BACK, H_DISP, H_FRONT) - 1);
  localparam logic [11:0] V_LAST  = 12'(calc_total(V_SYNC, V_BACK, V_DISP, V_FRONT) - 1);
  localparam logic [11:0] H_START = 12'(H_SYNC + H_BACK);
  localparam logic [11:0] V_START = 12'(V_SYNC + V_BACK);
  localparam logic [11:0] H_END   = 12'(H_SYNC + H_BACK + H_DISP);
  localparam logic [11:0] V_END   = 12'(V_SYNC + V_BACK + V_DISP);
  localparam logic [11:0] H_SW    = 12'(H_SYNC);
  localparam logic [11:0] V_SW    = 12'(V_SYNC);

  // The line counter only advances on the pixel-counter wrap, so both wrap on the same clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 12'd1;
    end else begin
      h_cnt <= h_cnt + 12'd1;
    end
  end

  assign h_act = (h_cnt >= H_START) && (h_cnt < H_END);
  assign v_act = (v_cnt >= V_START) && (v_cnt < V_END);
  assign hs0   = !(h_cnt < H_SW);
  assign vs0   = !(v_cnt < V_SW);

endmodule

// File: rtl/lcd_driver.sv
// Parallel-RGB LCD timing generator and output stage; define LCD_TEST_PATTERN_EN
// to replace lcd_data with an internal 8-colour bar pattern.
module lcd_driver
  import lcd_pkg::*;
#(
  parameter int H_SYNC  = H_SYNC_DEF,
  parameter int H_BACK  = H_BACK_DEF,
  parameter int H_DISP  = H_DISP_DEF,
  parameter int H_FRONT = H_FRONT_DEF,
  parameter int V_SYNC  = V_SYNC_DEF,
  parameter int V_BACK  = V_BACK_DEF,
  parameter int V_DISP  = V_DISP_DEF,
  parameter int V_FRONT = V_FRONT_DEF
) (
  input  logic         clk,
  input  logic         rst,
  lcd_driver_if.master bus
);

  localparam logic [11:0] H_START = 12'(H_SYNC + H_BACK);
  localparam logic [11:0] V_START = 12'(V_SYNC + V_BACK);

  logic [11:0] h_cnt;
  logic [11:0] v_cnt;
  logic        h_act;
  logic        v_act;
  logic        hs0;
  logic        vs0;
  logic        request;
  logic        first0;
  logic        de1;
  logic        hs1;
  logic        vs1;
  logic        first1;
  logic [23:0] pixel;

  lcd_timing_counter #(
    .H_SYNC (H_SYNC),  .H_BACK (H_BACK),  .H_DISP (H_DISP),  .H_FRONT(H_FRONT),
    .V_SYNC (V_SYNC),  .V_BACK (V_BACK),  .V_DISP (V_DISP),  .V_FRONT(V_FRONT)
  ) u_counter (
    .clk  (clk),
    .rst  (rst),
    .h_cnt(h_cnt),
    .v_cnt(v_cnt),
    .h_act(h_act),
    .v_act(v_act),
    .hs0  (hs0),
    .vs0  (vs0)
  );

  assign request         = h_act & v_act;
  assign first0          = request && (h_cnt == H_START) && (v_cnt == V_START);
  assign bus.lcd_request = request;
  assign bus.lcd_xpos    = request ? h_cnt - H_START : '0;
  assign bus.lcd_ypos    = request ? v_cnt - V_START : '0;

  // Flags wait here one clock while the data stage registers the coordinates.
  always_ff @(posedge clk) begin
    if (rst) begin
      de1    <= 1'b0;
      hs1    <= 1'b1;
      vs1    <= 1'b1;
      first1 <= 1'b0;
    end else begin
      de1    <= request;
      hs1    <= hs0;
      vs1    <= vs0;
      first1 <= first0;
    end
  end

`ifdef LCD_TEST_PATTERN_EN
  logic [11:0] xpos1;

  always_ff @(posedge clk) begin
    if (rst) begin
      xpos1 <= '0;
    end else begin
      xpos1 <= bus.lcd_xpos;
    end
  end

  assign pixel = bar_colour(3'({xpos1, 3'b000} / 15'(H_DISP)));
`else
  assign pixel = bus.lcd_data;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.lcd_de      <= 1'b0;
      bus.lcd_hs      <= 1'b1;
      bus.lcd_vs      <= 1'b1;
      bus.lcd_rgb     <= '0;
      bus.frame_start <= 1'b0;
    end else begin
      bus.lcd_de      <= de1;
      bus.lcd_hs      <= hs1;
      bus.lcd_vs      <= vs1;
      bus.lcd_rgb     <= de1 ? pixel : '0;
      bus.frame_start <= first1;
    end
  end

endmodule
